// File: rtl/hpu_axil_pkg.sv
// rtl/hpu_axil_pkg.sv - shared types and constants for the HPU AXI-Lite command master
package hpu_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WB,
    ST_RA,
    ST_RR,
    ST_RSP
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // HPU register file offsets programmed through this master
  localparam logic [11:0] REG_RUN_GEN = 12'h000;
  localparam logic [11:0] REG_CONTROL = 12'h010;

  // States in which a bus transaction is in flight and the watchdog runs
  function automatic logic is_busy(input axil_state_e s);
    return (s == ST_WR) || (s == ST_WB) || (s == ST_RA) || (s == ST_RR);
  endfunction

endpackage

// File: rtl/axil_cmd_master_if.sv
// rtl/axil_cmd_master_if.sv - AXI4-Lite bus bundle with master and slave views
interface axil_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

endinterface

// File: rtl/axil_watchdog.sv
// rtl/axil_watchdog.sv - cycle watchdog: load clears, enable counts, expire flags the last allowed cycle
module axil_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  // Count busy cycles since the last load; parks on the final value
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the LIMIT-th busy cycle so the owner leaves on that edge
  assign expire = enable && (count == LAST);

endmodule

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding AXI4-Lite initiator driven by a valid/ready command port; optional watchdog under AXIL_TIMEOUT_EN
module axil_cmd_master
  import hpu_axil_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESETN,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,

  axil_cmd_master_if.master   m_axi
);

  axil_state_e         state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                aw_done, w_done;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [1:0]          rsp_resp_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic cmd_accept;

  assign aw_hs      = awvalid_q && m_axi.M_AXI_AWREADY;
  assign w_hs       = wvalid_q  && m_axi.M_AXI_WREADY;
  assign b_hs       = bready_q  && m_axi.M_AXI_BVALID;
  assign ar_hs      = arvalid_q && m_axi.M_AXI_ARREADY;
  assign r_hs       = rready_q  && m_axi.M_AXI_RVALID;
  assign cmd_accept = cmd_valid && (state == ST_IDLE);

`ifdef AXIL_TIMEOUT_EN
  logic wd_expire;
  logic step_done;
  logic rsp_timeout_q;

  // A handshake that completes the current state on the expiry cycle takes priority
  assign step_done = ((state == ST_WR) && (aw_done || aw_hs) && (w_done || w_hs)) ||
                     ((state == ST_WB) && b_hs) ||
                     ((state == ST_RA) && ar_hs) ||
                     ((state == ST_RR) && r_hs);

  axil_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (M_AXI_ACLK),
    .resetn (M_AXI_ARESETN),
    .load   (cmd_accept),
    .enable (is_busy(state)),
    .expire (wd_expire)
  );

  assign rsp_timeout = rsp_timeout_q;
`else
  // No watchdog in this build: the flag is constant low
  assign rsp_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Transaction sequencer: every bus and response output comes straight from a register
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
`ifdef AXIL_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= {cmd_addr[ADDR_W-1:2], 2'b00};
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
`ifdef AXIL_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
            if (cmd_write) begin
              state     <= ST_WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end else begin
              state     <= ST_RA;
              arvalid_q <= 1'b1;
            end
          end
        end

        ST_WR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state    <= ST_WB;
            bready_q <= 1'b1;
          end
        end

        ST_WB: begin
          if (b_hs) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= m_axi.M_AXI_BRESP;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state       <= ST_RSP;
          end
        end

        ST_RA: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_RR;
          end
        end

        ST_RR: begin
          if (r_hs) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= m_axi.M_AXI_RDATA;
            rsp_resp_q  <= m_axi.M_AXI_RRESP;
            rsp_valid_q <= 1'b1;
            state       <= ST_RSP;
          end
        end

        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

`ifdef AXIL_TIMEOUT_EN
      // Watchdog abort: drop every channel and report SLVERR; the interconnect needs a reset afterwards
      if (wd_expire && !step_done) begin
        awvalid_q     <= 1'b0;
        wvalid_q      <= 1'b0;
        bready_q      <= 1'b0;
        arvalid_q     <= 1'b0;
        rready_q      <= 1'b0;
        rsp_rdata_q   <= '0;
        rsp_resp_q    <= RESP_SLVERR;
        rsp_timeout_q <= 1'b1;
        rsp_valid_q   <= 1'b1;
        state         <= ST_RSP;
      end
`endif
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = wstrb_q;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - directed scoreboard bench for axil_cmd_master with a delay-programmable AXI-Lite slave
module tb_axil_cmd_master;
  import hpu_axil_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TO     = 16;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  axil_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axil_cmd_master #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .rsp_timeout   (rsp_timeout),
    .m_axi         (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;
  rsp_t exp_q[$];

  logic [31:0] model_mem [0:15];

  // slave knobs and observations
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit          aw_got, w_got, b_pend, r_pend, b_fire, r_fire;
  int          b_count = 0, r_count = 0;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [31:0] smem [0:15];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  task automatic slave_clear();
    bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_BVALID = 1'b0;  bus.M_AXI_BRESP = 2'b00;
    bus.M_AXI_RVALID = 1'b0;  bus.M_AXI_RRESP = 2'b00; bus.M_AXI_RDATA = '0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_fire = 0; r_fire = 0;
  endtask

  task automatic slave_step();
    if (!resetn) begin
      slave_clear();
      return;
    end
    if (b_fire) begin bus.M_AXI_BVALID = 1'b0; b_fire = 0; end
    if (r_fire) begin bus.M_AXI_RVALID = 1'b0; r_fire = 0; end
    if (b_pend) begin
      if (b_cnt >= b_delay) begin
        bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = bresp_val; b_pend = 0;
      end else b_cnt++;
    end
    if (bus.M_AXI_BVALID && !b_fire && bus.M_AXI_BREADY) begin b_fire = 1; b_count++; end
    if (r_pend) begin
      if (r_cnt >= r_delay) begin
        bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RRESP = rresp_val;
        bus.M_AXI_RDATA = smem[cap_araddr[5:2]]; r_pend = 0;
      end else r_cnt++;
    end
    if (bus.M_AXI_RVALID && !r_fire && bus.M_AXI_RREADY) begin r_fire = 1; r_count++; end
    if (bus.M_AXI_AWVALID) begin
      bus.M_AXI_AWREADY = (aw_cnt >= aw_delay);
      if (bus.M_AXI_AWREADY) begin cap_awaddr = bus.M_AXI_AWADDR; aw_got = 1; aw_cnt = 0; end
      else aw_cnt++;
    end else begin bus.M_AXI_AWREADY = 1'b0; aw_cnt = 0; end
    if (bus.M_AXI_WVALID) begin
      bus.M_AXI_WREADY = (w_cnt >= w_delay);
      if (bus.M_AXI_WREADY) begin
        cap_wdata = bus.M_AXI_WDATA; cap_wstrb = bus.M_AXI_WSTRB; w_got = 1; w_cnt = 0;
      end else w_cnt++;
    end else begin bus.M_AXI_WREADY = 1'b0; w_cnt = 0; end
    if (aw_got && w_got) begin
      smem[cap_awaddr[5:2]] = merge(smem[cap_awaddr[5:2]], cap_wdata, cap_wstrb);
      aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
    end
    if (bus.M_AXI_ARVALID) begin
      bus.M_AXI_ARREADY = (ar_delay >= 0) && (ar_cnt >= ar_delay);
      if (bus.M_AXI_ARREADY) begin cap_araddr = bus.M_AXI_ARADDR; r_pend = 1; r_cnt = 0; ar_cnt = 0; end
      else ar_cnt++;
    end else begin bus.M_AXI_ARREADY = 1'b0; ar_cnt = 0; end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) smem[i] = '0;
    slave_clear();
    forever begin
      @(posedge clk);
      #2;
      slave_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer a command, wait for acceptance, and record the response the model predicts
  task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit track);
    int n;
    rsp_t e;
    n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    check("cmd_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    if (track) begin
      if (wr) begin
        model_mem[a[5:2]] = merge(model_mem[a[5:2]], d, s);
        e = '{rdata: 32'h0, resp: bresp_val, to: 1'b0};
      end else begin
        e = '{rdata: model_mem[a[5:2]], resp: rresp_val, to: 1'b0};
      end
      exp_q.push_back(e);
    end
  endtask

  // Wait for a response, compare against the scoreboard head, optionally stall before consuming
  task automatic get_rsp(input int hold);
    int n;
    rsp_t e;
    logic [31:0] d0;
    logic [1:0]  r0;
    n = 0;
    while (!rsp_valid && n < 200) begin tick(); n++; end
    check("rsp_valid_seen", rsp_valid, 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check("rsp_rdata", rsp_rdata, e.rdata);
    check("rsp_resp", rsp_resp, e.resp);
    check("rsp_timeout", rsp_timeout, e.to);
    d0 = rsp_rdata; r0 = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      tick();
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, d0);
      check("hold_resp", rsp_resp, r0);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    if (hold > 0) check("cmd_ready_at_rsp_ready", cmd_ready, 0);
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
    check("cmd_ready_after_rsp", cmd_ready, 1);
  endtask

  initial begin
    int n, aw_hi, w_hi, rr_hi, br_hi, ar_hi, b0;
    rsp_t e;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    resetn = 1'b0; rsp_ready = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) tick();

    // reset state
    check("rst_awvalid", bus.M_AXI_AWVALID, 0);
    check("rst_wvalid", bus.M_AXI_WVALID, 0);
    check("rst_bready", bus.M_AXI_BREADY, 0);
    check("rst_arvalid", bus.M_AXI_ARVALID, 0);
    check("rst_rready", bus.M_AXI_RREADY, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp", rsp_resp, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_awaddr", bus.M_AXI_AWADDR, 0);
    resetn = 1'b1;
    tick();
    check("idle_cmd_ready", cmd_ready, 1);

    // zero-wait write of {run,gen}: AW/W at c1, BREADY at c2, response at c3
    b0 = b_count;
    send(1'b1, 32'(REG_RUN_GEN), 32'h3, 4'hF, 1'b1);
    check("c1_awvalid", bus.M_AXI_AWVALID, 1);
    check("c1_wvalid", bus.M_AXI_WVALID, 1);
    check("c1_awaddr", bus.M_AXI_AWADDR, 32'h0);
    check("c1_wdata", bus.M_AXI_WDATA, 32'h3);
    check("c1_cmd_ready", cmd_ready, 0);
    check("c1_bready", bus.M_AXI_BREADY, 0);
    tick();
    check("c2_bready", bus.M_AXI_BREADY, 1);
    check("c2_awvalid", bus.M_AXI_AWVALID, 0);
    check("c2_wvalid", bus.M_AXI_WVALID, 0);
    check("c2_rsp_valid", rsp_valid, 0);
    tick();
    check("c3_rsp_valid", rsp_valid, 1);
    check("c3_bready", bus.M_AXI_BREADY, 0);
    get_rsp(0);
    check("wr1_b_count", b_count - b0, 1);

    // W accepted three cycles before AW
    aw_delay = 3; b0 = b_count; aw_hi = 0; w_hi = 0; n = 0;
    send(1'b1, 32'(REG_CONTROL), 32'hDEADBEEF, 4'hF, 1'b1);
    while (!rsp_valid && n < 50) begin
      aw_hi += int'(bus.M_AXI_AWVALID);
      w_hi  += int'(bus.M_AXI_WVALID);
      tick(); n++;
    end
    check("wr2_awvalid_cycles", aw_hi, 4);
    check("wr2_wvalid_cycles", w_hi, 1);
    check("wr2_b_count", b_count - b0, 1);
    get_rsp(0);
    aw_delay = 0;

    // read back with RVALID four cycles late
    r_delay = 4; rr_hi = 0; br_hi = 0; n = 0;
    send(1'b0, 32'(REG_CONTROL), 32'h0, 4'h0, 1'b1);
    check("rd_c1_arvalid", bus.M_AXI_ARVALID, 1);
    check("rd_c1_araddr", bus.M_AXI_ARADDR, 32'h10);
    while (!rsp_valid && n < 50) begin
      rr_hi += int'(bus.M_AXI_RREADY);
      br_hi += int'(bus.M_AXI_BREADY);
      tick(); n++;
    end
    check("rd_rready_cycles", rr_hi, 5);
    check("rd_bready_cycles", br_hi, 0);
    check("rd_rready_after", bus.M_AXI_RREADY, 0);
    get_rsp(0);
    r_delay = 0;

    // unaligned address, partial strobe, SLVERR passthrough, stalled consumer
    bresp_val = RESP_SLVERR;
    send(1'b1, 32'h0000_0013, 32'hCAFE1234, 4'b0011, 1'b1);
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    check("unal_awaddr", cap_awaddr, 32'h10);
    check("unal_wstrb", cap_wstrb, 4'b0011);
    get_rsp(5);
    bresp_val = RESP_OKAY;

    send(1'b0, 32'(REG_CONTROL), 32'h0, 4'h0, 1'b1);
    get_rsp(0);

    // read error passthrough
    rresp_val = RESP_SLVERR;
    send(1'b0, 32'(REG_RUN_GEN), 32'h0, 4'h0, 1'b1);
    get_rsp(0);
    rresp_val = RESP_OKAY;

    // reset while in WR
    aw_delay = 5; w_delay = 5;
    send(1'b1, 32'h0, 32'h77, 4'hF, 1'b0);
    tick();
    check("wr_hold_awvalid", bus.M_AXI_AWVALID, 1);
    check("wr_hold_wvalid", bus.M_AXI_WVALID, 1);
    resetn = 1'b0;
    tick();
    check("mid_rst_awvalid", bus.M_AXI_AWVALID, 0);
    check("mid_rst_wvalid", bus.M_AXI_WVALID, 0);
    check("mid_rst_bready", bus.M_AXI_BREADY, 0);
    check("mid_rst_arvalid", bus.M_AXI_ARVALID, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_idle", cmd_ready, 1);
    resetn = 1'b1;
    aw_delay = 0; w_delay = 0;
    tick();
    send(1'b1, 32'(REG_RUN_GEN), 32'h5, 4'hF, 1'b1);
    get_rsp(0);
    send(1'b0, 32'(REG_RUN_GEN), 32'h0, 4'h0, 1'b1);
    get_rsp(0);

`ifdef AXIL_TIMEOUT_EN
    // slave never accepts AR: watchdog aborts after TO cycles
    ar_delay = -1; ar_hi = 0; n = 0;
    send(1'b0, 32'(REG_CONTROL), 32'h0, 4'h0, 1'b0);
    e = '{rdata: 32'h0, resp: RESP_SLVERR, to: 1'b1};
    exp_q.push_back(e);
    while (bus.M_AXI_ARVALID && n < 100) begin ar_hi++; tick(); n++; end
    check("to_arvalid_cycles", ar_hi, TO);
    check("to_arvalid_low", bus.M_AXI_ARVALID, 0);
    check("to_rready_low", bus.M_AXI_RREADY, 0);
    get_rsp(0);
    ar_delay = 0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
`else
    // slave stalls AR for a long time: the master keeps waiting
    ar_delay = -1; ar_hi = 0;
    send(1'b0, 32'(REG_CONTROL), 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      ar_hi += int'(bus.M_AXI_ARVALID);
      tick();
    end
    check("stall_arvalid_cycles", ar_hi, 40);
    check("stall_rsp_valid", rsp_valid, 0);
    check("stall_rsp_timeout", rsp_timeout, 0);
    ar_delay = 0;
    get_rsp(0);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
